instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the decode-side immediate extraction: packs operand fields plus a sign-extended XLEN
//  immediate into a 32-bit RV32/RV64 base instruction word (R/I/S/B/U/J formats).
//  Used by the self-test instruction sequencer and the bench stimulus path to feed the fetch stage.
//  Valid/ready on both sides, 1-cycle latency, 2-entry output FIFO.
//  Out-of-range immediates are flagged and counted, never silently dropped.
// PARAMETERS
//  XLEN         32  width of imm input (32 or 64)
//  ERR_CNT_W    16  width of saturating error counter
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          asynchronous, active-low reset
//  flush        in   1          synchronous: empties FIFO, drops same-cycle accept
//  in_valid     in   1          request valid
//  in_ready     out  1          request accepted when in_valid&&in_ready
//  in_fmt       in   3          0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//  in_opcode    in   7          instr[6:0]
//  in_rd        in   5          instr[11:7] (R/I/U/J)
//  in_rs1       in   5          instr[19:15] (R/I/S/B)
//  in_rs2       in   5          instr[24:20] (R/S/B)
//  in_funct3    in   3          instr[14:12] (R/I/S/B)
//  in_funct7    in   7          instr[31:25] (R only)
//  in_imm       in   XLEN       sign-extended byte immediate (ignored for R)
//  out_valid    out  1          FIFO head valid
//  out_ready    in   1          consumer pop when out_valid&&out_ready
//  out_instr    out  32         encoded word at FIFO head
//  out_err      out  1          head word's immediate out of range / illegal fmt
//  err_count    out  ERR_CNT_W  saturating count of accepted requests with err
// BEHAVIOUR
//  Reset: FIFO count=0, out_valid=0, out_instr=0, out_err=0, err_count=0; in_ready=1 from first edge.
//  in_ready = (count != 2); depends on registered count only, never on in_valid or out_ready.
//  Accept at edge N -> word in FIFO at N; out_valid=1 after N if FIFO was empty (1-cycle latency).
//  Push and pop same edge: count unchanged, order kept. Pop on empty impossible (out_valid=0).
//  FIFO strictly in order; out_instr/out_err stable while out_valid && !out_ready.
//  flush: count->0, out_valid->0 next edge; a same-cycle accept is discarded, err_count unchanged.
//  Packing (imm = in_imm):
//   R: {f7,rs2,rs1,f3,rd,op}          I: {imm[11:0],rs1,f3,rd,op}
//   S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
//   U: {imm[31:12],rd,op}             J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//  Range err (word still emitted with truncated fields):
//   I/S: imm[XLEN-1:11] not all equal; B: imm[XLEN-1:12] not all equal or imm[0]=1
//   J: imm[XLEN-1:20] not all equal or imm[0]=1
//   U: imm[11:0]!=0, or XLEN=64 and imm[63:31] not all equal; R: never
//  Illegal fmt 6/7: out_instr=32'h0000_0013 (NOP), err=1.
//  err_count +1 per accepted errored request, saturates at all-ones, cleared only by rst_n.
//  rst_n low mid-operation: all state cleared immediately; in-flight and queued words lost.
// TESTING
//  I addi x1,x0,5 (op=13,rd=1,f3=0,imm=5) -> out_instr=0x00500093, out_err=0, next cycle
//  S sw x2,-4(x1) (op=23,rs1=1,rs2=2,f3=2,imm=-4) -> 0xFE20AE23; U lui x5 imm=0x12345000 -> 0x123452B7
//  B beq x0,x0,8 -> 0x00000463 err=0; B imm=3 -> err=1, err_count 0->1; I imm=2048 -> err=1, count 2
//  J jal x1,2048 (op=6F,rd=1) -> 0x001000EF; fmt=7 -> 0x00000013, err=1
//  out_ready=0, 3 back-to-back requests -> in_ready low after 2nd accept; release -> 3 words in order
//  FIFO holding 2 words, assert rst_n=0 -> out_valid=0, err_count=0 at once; flush -> out_valid=0 next edge

Source files
------------

// File: rtl/instr_encoder.sv
// Packs operand fields and a sign-extended immediate into a 32-bit RV32/RV64 base instruction word.
// Latency: one cycle from accept to word at the head of a 2-entry output FIFO.
// Backpressure: in_ready drops when the FIFO holds two words; the head is held stable until popped.

// Small generic FIFO holding {err, instr}; flush discards content and any same-cycle push.
module instr_fifo #(
  parameter int DW    = 33,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push_vld,
  input  logic [DW-1:0] i_push_dat,
  output logic          o_push_rdy,
  output logic          o_pop_vld,
  input  logic          i_pop_rdy,
  output logic [DW-1:0] o_pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Ready depends on registered occupancy only, never on the other handshake inputs.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign o_push_rdy = !w_full;
  assign o_pop_vld  = !w_empty;
  assign o_pop_dat  = w_empty ? '0 : r_mem[r_rptr];

  assign w_push = i_push_vld && !w_full && !i_flush;
  assign w_pop  = i_pop_rdy && !w_empty && !i_flush;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage, pointers and occupancy; flush wins over push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= next_ptr(r_wptr);
      end
      if (w_pop) r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module instr_encoder #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [XLEN-1:0]      in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Upper immediate slices that must be pure sign extension for each format.
  logic [XLEN-12:0] w_hi11;
  logic [XLEN-13:0] w_hi12;
  logic [XLEN-21:0] w_hi20;
  logic [XLEN-32:0] w_hi31;
  logic             w_hi11_ok;
  logic             w_hi12_ok;
  logic             w_hi20_ok;
  logic             w_hi31_ok;
  logic [31:0]      w_imm;

  logic [31:0] w_enc_instr;
  logic        w_enc_err;
  logic        w_acc;
  logic        w_cnt_inc;
  logic [32:0] w_fifo_out;

  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_imm  = in_imm[31:0];
  assign w_hi11 = in_imm[XLEN-1:11];
  assign w_hi12 = in_imm[XLEN-1:12];
  assign w_hi20 = in_imm[XLEN-1:20];
  assign w_hi31 = in_imm[XLEN-1:31];

  // A slice is a valid sign extension when it is all ones or all zeros.
  assign w_hi11_ok = (&w_hi11) || !(|w_hi11);
  assign w_hi12_ok = (&w_hi12) || !(|w_hi12);
  assign w_hi20_ok = (&w_hi20) || !(|w_hi20);
  assign w_hi31_ok = (&w_hi31) || !(|w_hi31);

  // Field packing and range check; out-of-range words are still emitted with truncated fields.
  always_comb begin
    w_enc_instr = NOP_WORD;
    w_enc_err   = 1'b1;
    case (in_fmt)
      FMT_R: begin
        w_enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        w_enc_err   = 1'b0;
      end
      FMT_I: begin
        w_enc_instr = {w_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_enc_err   = !w_hi11_ok;
      end
      FMT_S: begin
        w_enc_instr = {w_imm[11:5], in_rs2, in_rs1, in_funct3, w_imm[4:0], in_opcode};
        w_enc_err   = !w_hi11_ok;
      end
      FMT_B: begin
        w_enc_instr = {w_imm[12], w_imm[10:5], in_rs2, in_rs1, in_funct3,
                       w_imm[4:1], w_imm[11], in_opcode};
        w_enc_err   = !w_hi12_ok || w_imm[0];
      end
      FMT_U: begin
        w_enc_instr = {w_imm[31:12], in_rd, in_opcode};
        // For XLEN=32 the upper slice is a single bit and always passes.
        w_enc_err   = (w_imm[11:0] != 12'h000) || !w_hi31_ok;
      end
      FMT_J: begin
        w_enc_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], in_rd, in_opcode};
        w_enc_err   = !w_hi20_ok || w_imm[0];
      end
      default: begin
        w_enc_instr = NOP_WORD;
        w_enc_err   = 1'b1;
      end
    endcase
  end

  // A flushed accept is discarded entirely, so it must not count as an error either.
  assign w_acc     = in_valid && in_ready;
  assign w_cnt_inc = w_acc && w_enc_err && !flush;

  // Saturating error counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_cnt_inc && !(&r_err_count)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  instr_fifo #(
    .DW    (33),
    .DEPTH (2)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_push_vld (in_valid),
    .i_push_dat ({w_enc_err, w_enc_instr}),
    .o_push_rdy (in_ready),
    .o_pop_vld  (out_valid),
    .i_pop_rdy  (out_ready),
    .o_pop_dat  (w_fifo_out)
  );

  assign out_instr = w_fifo_out[31:0];
  assign out_err   = w_fifo_out[32];
  assign err_count = r_err_count;
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int XLEN = 32;
  localparam int ECW  = 4;
  localparam int ESAT = (1 << ECW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_fmt;
  logic [6:0]      in_opcode;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [XLEN-1:0] in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_err;
  logic [ECW-1:0]  err_count;

  instr_encoder #(.XLEN(XLEN), .ERR_CNT_W(ECW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } ent_t;

  ent_t q[$];
  int   m_errcnt;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  // Reference encoder: places fields by arithmetic and checks ranges on the signed value.
  function automatic ent_t model_enc(input req_t r);
    ent_t        e;
    longint      v;
    logic [31:0] u;
    logic [31:0] regs;
    v = longint'($signed(r.imm));
    u = r.imm;
    e.err = 1'b0;
    regs = (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | 32'(r.op);
    case (r.fmt)
      3'd0: e.instr = (32'(r.f7) << 25) | regs | (32'(r.rd) << 7);
      3'd1: begin
        e.instr = ((u % 4096) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12)
                | (32'(r.rd) << 7) | 32'(r.op);
        e.err = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        e.instr = (((u / 32) % 128) << 25) | regs | ((u % 32) << 7);
        e.err = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        e.instr = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | regs
                | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7);
        e.err = (v < -4096) || (v > 4095) || (u % 2 != 0);
      end
      3'd4: begin
        e.instr = ((u / 4096) * 4096) | (32'(r.rd) << 7) | 32'(r.op);
        e.err = (u % 4096 != 0);
      end
      3'd5: begin
        e.instr = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21)
                | (((u / 2048) % 2) << 20) | (((u / 4096) % 256) << 12)
                | (32'(r.rd) << 7) | 32'(r.op);
        e.err = (v < -1048576) || (v > 1048575) || (u % 2 != 0);
      end
      default: begin
        e.instr = 32'h0000_0013;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic compare_all();
    chk("in_ready", 64'(in_ready), 64'(q.size() != 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_instr", 64'(out_instr), 64'(q[0].instr));
      chk("out_err", 64'(out_err), 64'(q[0].err));
    end
    chk("err_count", 64'(err_count), 64'(m_errcnt));
  endtask

  // Drive one cycle at a negedge, advance the model to the next edge, then compare.
  task automatic step(input logic v, input req_t r, input logic ordy, input logic fl);
    bit   acc;
    bit   pop;
    ent_t e;
    in_valid = v; in_fmt = r.fmt; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1;
    in_rs2 = r.rs2; in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
    out_ready = ordy; flush = fl;
    acc = v && (q.size() != 2);
    pop = ordy && (q.size() != 0);
    e = model_enc(r);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (acc && e.err && m_errcnt != ESAT) m_errcnt++;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    q.delete();
    m_errcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] pick_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return r;
      1: return 32'($signed($urandom_range(0, 31)) - 16);
      2: case ($urandom_range(0, 13))
           0: return 32'd2047;       1: return 32'd2048;
           2: return -32'sd2048;     3: return -32'sd2049;
           4: return 32'd4094;       5: return 32'd4096;
           6: return -32'sd4096;     7: return -32'sd4098;
           8: return 32'd1048574;    9: return 32'd1048576;
           10: return -32'sd1048576; 11: return -32'sd1048578;
           12: return 32'h8000_0000; default: return 32'h7FFF_F000;
         endcase
      3: return r & 32'hFFFF_F000;
      default: return 32'($signed(r[21:0])) & 32'hFFFF_FFFE;
    endcase
  endfunction

  req_t idle;
  req_t ra, rb, rc, rerr;

  initial begin
    checks = 0; errors = 0; m_errcnt = 0;
    idle = mk(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_instr", 64'(out_instr), 64'd0);
    chk("reset_out_err", 64'(out_err), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();

    // Literal vectors pin both the model and the DUT.
    ra = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
    chk("model_addi", 64'(model_enc(ra).instr), 64'h0050_0093);
    step(1'b1, ra, 1'b1, 1'b0);
    chk("addi_word", 64'(out_instr), 64'h0050_0093);
    chk("addi_err", 64'(out_err), 64'd0);

    ra = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0, -32'sd4);
    chk("model_sw", 64'(model_enc(ra).instr), 64'hFE20_AE23);
    step(1'b1, ra, 1'b1, 1'b0);
    chk("sw_word", 64'(out_instr), 64'hFE20_AE23);

    ra = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5000);
    step(1'b1, ra, 1'b1, 1'b0);
    chk("lui_word", 64'(out_instr), 64'h1234_52B7);

    ra = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd8);
    step(1'b1, ra, 1'b1, 1'b0);
    chk("beq_word", 64'(out_instr), 64'h0000_0463);
    chk("beq_err", 64'(out_err), 64'd0);

    ra = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3);
    step(1'b1, ra, 1'b1, 1'b0);
    chk("b_odd_err", 64'(out_err), 64'd1);
    chk("b_odd_count", 64'(err_count), 64'd1);

    ra = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048);
    step(1'b1, ra, 1'b1, 1'b0);
    chk("i2048_err", 64'(out_err), 64'd1);
    chk("i2048_count", 64'(err_count), 64'd2);

    ra = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048);
    chk("model_jal", 64'(model_enc(ra).instr), 64'h0010_00EF);
    step(1'b1, ra, 1'b1, 1'b0);
    chk("jal_word", 64'(out_instr), 64'h0010_00EF);
    chk("jal_err", 64'(out_err), 64'd0);

    ra = mk(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h0, 32'd0);
    step(1'b1, ra, 1'b1, 1'b0);
    chk("fmt7_word", 64'(out_instr), 64'h0000_0013);
    chk("fmt7_err", 64'(out_err), 64'd1);
    chk("fmt7_count", 64'(err_count), 64'd3);
    step(1'b0, idle, 1'b1, 1'b0);

    // Backpressure: three back-to-back requests against a stalled consumer.
    ra = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
    rb = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    rc = mk(3'd0, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
    step(1'b1, ra, 1'b0, 1'b0);
    chk("bp_ready_after1", 64'(in_ready), 64'd1);
    step(1'b1, rb, 1'b0, 1'b0);
    chk("bp_ready_after2", 64'(in_ready), 64'd0);
    chk("bp_head_a", 64'(out_instr), 64'h0020_81B3);
    step(1'b1, rc, 1'b0, 1'b0);
    chk("bp_head_stable", 64'(out_instr), 64'h0020_81B3);
    step(1'b1, rc, 1'b1, 1'b0);
    chk("bp_head_b", 64'(out_instr), 64'h4020_81B3);
    step(1'b1, rc, 1'b1, 1'b0);
    chk("bp_head_c", 64'(out_instr), 64'h0020_8233);
    step(1'b0, idle, 1'b1, 1'b0);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset with two words queued.
    step(1'b1, ra, 1'b0, 1'b0);
    step(1'b1, rb, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_err_count", 64'(err_count), 64'd0);
    do_reset();

    // Flush drops the queued word and the same-cycle errored accept.
    rerr = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd4096);
    step(1'b1, rerr, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(err_count), 64'd1);
    step(1'b1, rerr, 1'b0, 1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_err_count", 64'(err_count), 64'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      req_t r;
      r = mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 3'($urandom), 7'($urandom), pick_imm());
      step($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end

    // Counter saturation at all-ones.
    do_reset();
    for (int n = 0; n < 14; n++) step(1'b1, rerr, 1'b1, 1'b0);
    chk("sat_count14", 64'(err_count), 64'd14);
    for (int n = 0; n < 5; n++) step(1'b1, rerr, 1'b1, 1'b0);
    chk("sat_count_max", 64'(err_count), 64'(ESAT));
    step(1'b0, idle, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
